// File: rtl/m92_pkg.sv
// Shared types for the M92 core: ROM load region table, board config byte,
// and the ROM loader state encoding.
package m92_pkg;

   // One entry of the ROM download table. A non-zero bram_cs routes the
   // region to an on-chip BRAM; otherwise it goes to SDRAM at base_addr.
   typedef struct packed {
      logic [24:0] base_addr;
      logic        reorder_64;
      logic [7:0]  bram_cs;
      logic [24:0] max_len;
   } load_region_t;

   // Board configuration byte appended after the last ROM region.
   typedef struct packed {
      logic [2:0] reserved;
      logic       kick_harness;
      logic [3:0] board_id;
   } board_cfg_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_SDR_WAIT,
      ST_CFG,
      ST_DONE
   } loader_state_t;

   // Default M92 table, in stream order. Element 0 is the rightmost entry.
   localparam load_region_t [5:0] LOAD_REGIONS_V2 = {
      load_region_t'{25'h0000000, 1'b0, 8'h02, 25'h0000800},  // 5: palette/eeprom BRAM
      load_region_t'{25'h0400000, 1'b0, 8'h00, 25'h0080000},  // 4: sound samples
      load_region_t'{25'h0000000, 1'b0, 8'h01, 25'h0020000},  // 3: sound cpu BRAM
      load_region_t'{25'h0200000, 1'b1, 8'h00, 25'h0200000},  // 2: sprites, reordered
      load_region_t'{25'h0100000, 1'b1, 8'h00, 25'h0100000},  // 1: tiles, reordered
      load_region_t'{25'h0000000, 1'b0, 8'h00, 25'h0100000}   // 0: main cpu
   };

endpackage

// File: rtl/rom_addr_swizzle.sv
// Maps a byte offset within a region to an SDRAM word address: optional
// 64-byte block reorder, then base add, with bit 0 forced low.
module rom_addr_swizzle #(
   parameter int ADDR_W = 25
) (
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              reorder_64,
   input  logic [ADDR_W-1:0] offset,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] swz;

   // Reorder swaps offset fields [5:3] and [2:1] inside each 64-byte block.
   always_comb begin
      if (reorder_64)
         swz = {offset[ADDR_W-1:6], offset[2:1], offset[5:3], offset[0]};
      else
         swz = offset;
      addr    = base_addr + swz;
      addr[0] = 1'b0;
   end

endmodule

// File: rtl/rom_loader.sv
// ROM download scatter engine: parses the ioctl byte stream into
// length-prefixed regions, writes them to SDRAM (16-bit words) or BRAM
// (bytes), then captures a trailing board config byte.
module rom_loader
   import m92_pkg::*;
#(
   parameter int                               NUM_REGIONS = 6,
   parameter load_region_t [NUM_REGIONS-1:0]   REGIONS     = LOAD_REGIONS_V2,
   parameter int                               ADDR_W      = 25
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic              sdr_req,
   output logic [ADDR_W-1:0] sdr_addr,
   output logic [15:0]       sdr_data,
   output logic [1:0]        sdr_be,
   input  logic              sdr_ack,
   output logic [7:0]        bram_cs,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [7:0]        bram_data,
   output logic              bram_we,
   output logic [2:0]        cur_region,
   output logic [7:0]        board_cfg,
   output logic              load_done,
   output logic              load_error
);

   loader_state_t     state_reg, state_next;
   logic [2:0]        region_reg, region_next;
   logic [ADDR_W-1:0] len_reg, len_next;
   logic [1:0]        len_cnt_reg, len_cnt_next;
   logic [ADDR_W-1:0] offset_reg, offset_next;
   logic [7:0]        lo_byte_reg, lo_byte_next;
   logic              abort_reg, abort_next;
   logic              dl_prev_reg;
   logic              req_reg, req_next;
   logic              wait_reg, wait_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [15:0]       data_reg, data_next;
   logic [1:0]        be_reg, be_next;
   logic [7:0]        bram_cs_reg, bram_cs_next;
   logic [ADDR_W-1:0] bram_addr_reg, bram_addr_next;
   logic [7:0]        bram_data_reg, bram_data_next;
   logic              bram_we_reg, bram_we_next;
   logic [7:0]        cfg_reg, cfg_next;
   logic              done_reg, done_next;
   logic              error_reg, error_next;

   load_region_t      cur_def;
   logic [ADDR_W-1:0] launch_addr;
   logic [31:0]       full_len;
   logic              last_byte;
   logic              region_done;
   logic              dl_rise, dl_fall;

   assign dl_rise = ioctl_download & ~dl_prev_reg;
   assign dl_fall = ~ioctl_download & dl_prev_reg;

   // Select the table entry for the region currently being loaded.
   always_comb begin
      cur_def = '0;
      for (int i = 0; i < NUM_REGIONS; i++)
         if (region_reg == 3'(i))
            cur_def = REGIONS[i];
   end

   rom_addr_swizzle #(.ADDR_W(ADDR_W)) u_swizzle (
      .base_addr  (ADDR_W'(cur_def.base_addr)),
      .reorder_64 (cur_def.reorder_64),
      .offset     (offset_reg),
      .addr       (launch_addr)
   );

   // Next-state and registered-output logic; a byte arriving together with
   // a download drop is consumed before the abort is applied.
   always_comb begin
      state_next     = state_reg;
      region_next    = region_reg;
      len_next       = len_reg;
      len_cnt_next   = len_cnt_reg;
      offset_next    = offset_reg;
      lo_byte_next   = lo_byte_reg;
      abort_next     = abort_reg;
      req_next       = req_reg;
      wait_next      = wait_reg;
      addr_next      = addr_reg;
      data_next      = data_reg;
      be_next        = be_reg;
      bram_cs_next   = 8'h00;
      bram_addr_next = bram_addr_reg;
      bram_data_next = bram_data_reg;
      bram_we_next   = 1'b0;
      cfg_next       = cfg_reg;
      done_next      = done_reg;
      error_next     = error_reg;
      region_done    = 1'b0;
      full_len       = {len_reg[23:0], ioctl_dout};
      last_byte      = (offset_reg + ADDR_W'(1)) == len_reg;

      case (state_reg)
         ST_IDLE: begin
            if (dl_rise) begin
               done_next    = 1'b0;
               error_next   = 1'b0;
               region_next  = 3'd0;
               len_next     = '0;
               len_cnt_next = 2'd0;
               offset_next  = '0;
               state_next   = ST_LEN;
            end
         end
         ST_LEN: begin
            if (ioctl_wr) begin
               len_next     = ADDR_W'(full_len);
               len_cnt_next = len_cnt_reg + 2'd1;
               if (len_cnt_reg == 2'd3) begin
                  if (full_len == 32'd0) begin
                     region_done = 1'b1;
                  end else if (full_len > {7'd0, cur_def.max_len}) begin
                     error_next = 1'b1;
                     state_next = ST_IDLE;
                  end else begin
                     offset_next = '0;
                     state_next  = ST_DATA;
                  end
               end
            end
         end
         ST_DATA: begin
            if (ioctl_wr) begin
               offset_next = offset_reg + ADDR_W'(1);
               if (cur_def.bram_cs != 8'h00) begin
                  bram_we_next   = 1'b1;
                  bram_cs_next   = cur_def.bram_cs;
                  bram_addr_next = offset_reg;
                  bram_data_next = ioctl_dout;
                  region_done    = last_byte;
               end else if (!offset_reg[0] && !last_byte) begin
                  lo_byte_next = ioctl_dout;
               end else begin
                  req_next   = 1'b1;
                  wait_next  = 1'b1;
                  addr_next  = launch_addr;
                  state_next = ST_SDR_WAIT;
                  if (offset_reg[0]) begin
                     data_next = {ioctl_dout, lo_byte_reg};
                     be_next   = 2'b11;
                  end else begin
                     data_next = {8'h00, ioctl_dout};
                     be_next   = 2'b01;
                  end
               end
            end
         end
         ST_SDR_WAIT: begin
            if (ioctl_wr)
               error_next = 1'b1;
            if (dl_fall) begin
               error_next = 1'b1;
               abort_next = 1'b1;
            end
            if (sdr_ack) begin
               req_next  = 1'b0;
               wait_next = 1'b0;
               if (abort_reg || dl_fall) begin
                  abort_next = 1'b0;
                  state_next = ST_IDLE;
               end else if (offset_reg == len_reg) begin
                  region_done = 1'b1;
               end else begin
                  state_next = ST_DATA;
               end
            end
         end
         ST_CFG: begin
            if (ioctl_wr) begin
               cfg_next   = ioctl_dout;
               done_next  = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (dl_fall)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      if (region_done) begin
         if (region_reg == 3'(NUM_REGIONS - 1)) begin
            state_next = ST_CFG;
         end else begin
            region_next  = region_reg + 3'd1;
            len_next     = '0;
            len_cnt_next = 2'd0;
            state_next   = ST_LEN;
         end
      end

      if (dl_fall && (state_reg == ST_LEN || state_reg == ST_DATA || state_reg == ST_CFG)) begin
         if (state_next == ST_SDR_WAIT) begin
            abort_next = 1'b1;
            error_next = 1'b1;
         end else if (state_next == ST_DONE) begin
            state_next = ST_IDLE;
         end else begin
            error_next = 1'b1;
            state_next = ST_IDLE;
         end
      end
   end

   // State and output registers, cleared asynchronously by reset_n.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         region_reg    <= 3'd0;
         len_reg       <= '0;
         len_cnt_reg   <= 2'd0;
         offset_reg    <= '0;
         lo_byte_reg   <= 8'h00;
         abort_reg     <= 1'b0;
         dl_prev_reg   <= 1'b0;
         req_reg       <= 1'b0;
         wait_reg      <= 1'b0;
         addr_reg      <= '0;
         data_reg      <= 16'h0000;
         be_reg        <= 2'b00;
         bram_cs_reg   <= 8'h00;
         bram_addr_reg <= '0;
         bram_data_reg <= 8'h00;
         bram_we_reg   <= 1'b0;
         cfg_reg       <= 8'h00;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         region_reg    <= region_next;
         len_reg       <= len_next;
         len_cnt_reg   <= len_cnt_next;
         offset_reg    <= offset_next;
         lo_byte_reg   <= lo_byte_next;
         abort_reg     <= abort_next;
         dl_prev_reg   <= ioctl_download;
         req_reg       <= req_next;
         wait_reg      <= wait_next;
         addr_reg      <= addr_next;
         data_reg      <= data_next;
         be_reg        <= be_next;
         bram_cs_reg   <= bram_cs_next;
         bram_addr_reg <= bram_addr_next;
         bram_data_reg <= bram_data_next;
         bram_we_reg   <= bram_we_next;
         cfg_reg       <= cfg_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
      end
   end

   assign ioctl_wait = wait_reg;
   assign sdr_req    = req_reg;
   assign sdr_addr   = addr_reg;
   assign sdr_data   = data_reg;
   assign sdr_be     = be_reg;
   assign bram_cs    = bram_cs_reg;
   assign bram_addr  = bram_addr_reg;
   assign bram_data  = bram_data_reg;
   assign bram_we    = bram_we_reg;
   assign cur_region = region_reg;
   assign board_cfg  = cfg_reg;
   assign load_done  = done_reg;
   assign load_error = error_reg;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: four-region table covering plain SDRAM,
// reordered SDRAM, BRAM and odd-length SDRAM regions, plus error paths.
module tb_rom_loader;
   import m92_pkg::*;

   localparam int ADDR_W = 25;
   localparam load_region_t [3:0] TB_REGIONS = {
      load_region_t'{25'h0200000, 1'b0, 8'h00, 25'h0000010},  // 3: sdram, odd length
      load_region_t'{25'h0000000, 1'b0, 8'h01, 25'h0000010},  // 2: bram
      load_region_t'{25'h0400000, 1'b1, 8'h00, 25'h0000040},  // 1: sdram reordered
      load_region_t'{25'h0100000, 1'b0, 8'h00, 25'h0000040}   // 0: sdram plain
   };

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              ioctl_download = 1'b0;
   logic              ioctl_wr = 1'b0;
   logic [7:0]        ioctl_dout = 8'h00;
   logic              ioctl_wait;
   logic              sdr_req;
   logic [ADDR_W-1:0] sdr_addr;
   logic [15:0]       sdr_data;
   logic [1:0]        sdr_be;
   logic              sdr_ack = 1'b0;
   logic [7:0]        bram_cs;
   logic [ADDR_W-1:0] bram_addr;
   logic [7:0]        bram_data;
   logic              bram_we;
   logic [2:0]        cur_region;
   logic [7:0]        board_cfg;
   logic              load_done;
   logic              load_error;

   int n_vec = 0;
   int n_err = 0;
   logic ack_hold = 1'b0;
   logic in_bram_phase = 1'b0;
   int wait_in_bram = 0;

   logic [ADDR_W-1:0] log_addr[$];
   logic [15:0]       log_data[$];
   logic [1:0]        log_be[$];
   logic [7:0]        blog_cs[$];
   logic [ADDR_W-1:0] blog_addr[$];
   logic [7:0]        blog_data[$];

   always #5 clk_sys = ~clk_sys;

   rom_loader #(.NUM_REGIONS(4), .REGIONS(TB_REGIONS), .ADDR_W(ADDR_W)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be),
      .sdr_ack(sdr_ack), .bram_cs(bram_cs), .bram_addr(bram_addr),
      .bram_data(bram_data), .bram_we(bram_we), .cur_region(cur_region),
      .board_cfg(board_cfg), .load_done(load_done), .load_error(load_error)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_req(input string tag, input int idx, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] be);
      if (idx >= log_addr.size()) begin
         check_val({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
      end else begin
         check_val({tag, "_addr"}, 32'(log_addr[idx]), a);
         check_val({tag, "_data"}, 32'(log_data[idx]), d);
         check_val({tag, "_be"},   32'(log_be[idx]),   be);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys); #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      while (ioctl_wait && guard < 200) begin tick(); guard++; end
      if (guard >= 200) check_val("wait_timeout", 32'(ioctl_wait), 32'd0);
      ioctl_dout = b;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic force_byte(input logic [7:0] b);
      ioctl_dout = b;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] l);
      send_byte(l[31:24]); send_byte(l[23:16]); send_byte(l[15:8]); send_byte(l[7:0]);
   endtask

   // SDRAM arbiter model: logs each request, acks after a few cycles.
   initial begin : responder
      logic seen;
      int   hold_cnt;
      seen = 1'b0;
      hold_cnt = 0;
      forever begin
         tick();
         sdr_ack = 1'b0;
         if (sdr_req && !seen) begin
            seen = 1'b1;
            hold_cnt = 0;
            log_addr.push_back(sdr_addr);
            log_data.push_back(sdr_data);
            log_be.push_back(sdr_be);
            $display("sdr req addr=%h data=%h be=%b", sdr_addr, sdr_data, sdr_be);
            check_val("wait_with_req", 32'(ioctl_wait), 32'd1);
         end
         if (seen) begin
            if (!sdr_req) begin
               check_val("wait_after_ack", 32'(ioctl_wait), 32'd0);
               seen = 1'b0;
            end else if (!ack_hold) begin
               hold_cnt++;
               if (hold_cnt == 3) sdr_ack = 1'b1;
            end
         end
      end
   end

   // BRAM write monitor.
   initial begin : bram_mon
      forever begin
         tick();
         if (in_bram_phase && ioctl_wait) wait_in_bram++;
         if (bram_we) begin
            blog_cs.push_back(bram_cs);
            blog_addr.push_back(bram_addr);
            blog_data.push_back(bram_data);
            $display("bram we cs=%h addr=%h data=%h", bram_cs, bram_addr, bram_data);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      tick(); tick();
      check_val("rst_req",    32'(sdr_req),    32'd0);
      check_val("rst_wait",   32'(ioctl_wait), 32'd0);
      check_val("rst_done",   32'(load_done),  32'd0);
      check_val("rst_error",  32'(load_error), 32'd0);
      check_val("rst_cfg",    32'(board_cfg),  32'd0);
      check_val("rst_region", 32'(cur_region), 32'd0);
      check_val("rst_we",     32'(bram_we),    32'd0);
      reset_n = 1'b1;
      tick();

      // Stream 1: all four regions populated.
      ioctl_download = 1'b1;
      tick();
      send_len(32'd4);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_len(32'd64);
      for (int i = 0; i < 64; i++) send_byte(8'(i));
      while (ioctl_wait) tick();
      in_bram_phase = 1'b1;
      send_len(32'd3);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      tick();
      in_bram_phase = 1'b0;
      check_val("bram_reqs", 32'(log_addr.size()), 32'd34);
      check_val("bram_wait", 32'(wait_in_bram), 32'd0);
      check_val("region3", 32'(cur_region), 32'd3);
      send_len(32'd3);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      send_byte(8'h5A);
      check_val("s1_done",  32'(load_done),  32'd1);
      check_val("s1_error", 32'(load_error), 32'd0);
      check_val("s1_cfg",   32'(board_cfg),  32'h5A);

      check_req("r0_w0", 0, 32'h100000, 32'h2211, 32'd3);
      check_req("r0_w1", 1, 32'h100002, 32'h4433, 32'd3);
      check_req("r1_o0", 2, 32'h400000, 32'h0100, 32'd3);
      check_req("r1_o2", 3, 32'h400010, 32'h0302, 32'd3);
      check_req("r1_o6", 5, 32'h400030, 32'h0706, 32'd3);
      check_req("r1_o8", 6, 32'h400002, 32'h0908, 32'd3);
      check_req("r1_o56", 30, 32'h40000E, 32'h3938, 32'd3);
      check_req("r1_o62", 33, 32'h40003E, 32'h3F3E, 32'd3);
      check_req("r3_w0", 34, 32'h200000, 32'h0201, 32'd3);
      check_req("r3_tail", 35, 32'h200002, 32'h0003, 32'd1);
      check_val("bram_count", 32'(blog_addr.size()), 32'd3);
      for (int i = 0; i < 3 && i < blog_addr.size(); i++) begin
         check_val("bram_cs",   32'(blog_cs[i]),   32'h01);
         check_val("bram_addr", 32'(blog_addr[i]), 32'(i));
      end
      if (blog_data.size() == 3) begin
         check_val("bram_d0", 32'(blog_data[0]), 32'hAA);
         check_val("bram_d1", 32'(blog_data[1]), 32'hBB);
         check_val("bram_d2", 32'(blog_data[2]), 32'hCC);
      end
      // Bytes after the config byte are ignored.
      send_byte(8'hEE);
      check_val("done_ignore_cfg", 32'(board_cfg), 32'h5A);
      ioctl_download = 1'b0;
      tick(); tick();
      check_val("done_sticky", 32'(load_done), 32'd1);
      check_val("done_no_err", 32'(load_error), 32'd0);

      // Stream 2: zero-length middle regions.
      ioctl_download = 1'b1;
      tick();
      check_val("s2_done_clr", 32'(load_done), 32'd0);
      send_len(32'd2); send_byte(8'h05); send_byte(8'h06);
      send_len(32'd0);
      send_len(32'd1); send_byte(8'h77);
      send_len(32'd0);
      send_byte(8'h0F);
      check_val("s2_done",  32'(load_done),  32'd1);
      check_val("s2_error", 32'(load_error), 32'd0);
      check_val("s2_cfg",   32'(board_cfg),  32'h0F);
      check_req("s2_w0", 36, 32'h100000, 32'h0605, 32'd3);
      check_val("s2_bram_n", 32'(blog_addr.size()), 32'd4);
      if (blog_data.size() == 4) check_val("s2_bram_d", 32'(blog_data[3]), 32'h77);
      ioctl_download = 1'b0;
      tick(); tick();

      // Stream 3: length over max_len.
      ioctl_download = 1'b1;
      tick();
      send_len(32'h41);
      check_val("ovf_error", 32'(load_error), 32'd1);
      check_val("ovf_done",  32'(load_done),  32'd0);
      send_byte(8'h12); send_byte(8'h34);
      tick(); tick();
      check_val("ovf_no_req", 32'(log_addr.size()), 32'd37);
      ioctl_download = 1'b0;
      tick(); tick();

      // Stream 4: download dropped with a request in flight.
      ioctl_download = 1'b1;
      tick();
      ack_hold = 1'b1;
      send_len(32'd4); send_byte(8'h11); send_byte(8'h22);
      tick();
      ioctl_download = 1'b0;
      repeat (4) tick();
      check_val("abort_req_held", 32'(sdr_req), 32'd1);
      check_val("abort_addr_held", 32'(sdr_addr), 32'h100000);
      check_val("abort_error", 32'(load_error), 32'd1);
      ack_hold = 1'b0;
      repeat (6) tick();
      check_val("abort_req_gone", 32'(sdr_req), 32'd0);
      check_req("abort_w", 37, 32'h100000, 32'h2211, 32'd3);
      ioctl_download = 1'b1;
      tick();
      check_val("abort_idle_restart", 32'(load_error), 32'd0);

      // Stream 5: byte written during wait, then async reset mid-request.
      ack_hold = 1'b1;
      send_len(32'd2); send_byte(8'h33); send_byte(8'h44);
      check_val("s5_req", 32'(sdr_req), 32'd1);
      force_byte(8'h55);
      check_val("wr_in_wait_err", 32'(load_error), 32'd1);
      check_val("wr_in_wait_req", 32'(sdr_req), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("arst_req",   32'(sdr_req),    32'd0);
      check_val("arst_wait",  32'(ioctl_wait), 32'd0);
      check_val("arst_error", 32'(load_error), 32'd0);
      ioctl_download = 1'b0;
      ack_hold = 1'b0;
      tick();
      reset_n = 1'b1;
      tick(); tick();
      check_val("total_reqs", 32'(log_addr.size()), 32'd39);
      check_req("s5_w", 38, 32'h100000, 32'h4433, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
